// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings, NVZ flag bit
// positions, execute-stage FSM states and the operand forwarding helper.
package cpu_pkg;

    localparam int DataWidth    = 16;
    localparam int RegAddrWidth = 4;
    localparam int OpcodeWidth  = 5;

    localparam logic [OpcodeWidth-1:0] OpAdd       = 5'b00000;
    localparam logic [OpcodeWidth-1:0] OpSub       = 5'b00001;
    localparam logic [OpcodeWidth-1:0] OpAnd       = 5'b00010;
    localparam logic [OpcodeWidth-1:0] OpOr        = 5'b00011;
    localparam logic [OpcodeWidth-1:0] OpXor       = 5'b00100;
    localparam logic [OpcodeWidth-1:0] OpSll       = 5'b00101;
    localparam logic [OpcodeWidth-1:0] OpSrl       = 5'b00110;
    localparam logic [OpcodeWidth-1:0] OpMul       = 5'b00111;
    localparam logic [OpcodeWidth-1:0] OpImmL      = 5'b01000;
    localparam logic [OpcodeWidth-1:0] OpImmH      = 5'b01001;
    localparam logic [OpcodeWidth-1:0] OpLoad      = 5'b01010;
    localparam logic [OpcodeWidth-1:0] OpStore     = 5'b01011;
    localparam logic [OpcodeWidth-1:0] OpDbLoad    = 5'b01100;
    localparam logic [OpcodeWidth-1:0] OpDbStore   = 5'b01101;
    localparam logic [OpcodeWidth-1:0] OpBranch    = 5'b01110;
    localparam logic [OpcodeWidth-1:0] OpBranchReg = 5'b01111;

    // Bit positions inside the {N,V,Z} flag register.
    localparam int NvzN = 2;
    localparam int NvzV = 1;
    localparam int NvzZ = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } exState_t;

    // EX/MEM has priority over MEM/WB because it holds the younger value.
    function automatic logic [DataWidth-1:0] forwardOperand(
        input logic                    exMemValid,
        input logic [RegAddrWidth-1:0] exMemAddr,
        input logic [DataWidth-1:0]    exMemData,
        input logic                    wbValid,
        input logic [RegAddrWidth-1:0] wbAddr,
        input logic [DataWidth-1:0]    wbData,
        input logic [RegAddrWidth-1:0] srcAddr,
        input logic [DataWidth-1:0]    rfData
    );
        if (exMemValid && (exMemAddr == srcAddr)) begin
            return exMemData;
        end else if (wbValid && (wbAddr == srcAddr)) begin
            return wbData;
        end
        return rfData;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// 16x16 shift-add multiplier, one multiplier bit per cycle, low 16 bits kept.
// The start cycle already folds in bit 0, so count names the bit handled in
// the current cycle and the last bit (count==15) completes 16 cycles after
// start, with the final sum presented combinationally on oProduct.
// Ports:
//   iclk, irst      clock, synchronous active-high reset
//   iStart          load operands (ignored while busy)
//   iMultiplicand   operand A
//   iMultiplier     operand B
//   oBusy           iteration in progress
//   oDone           this cycle performs the final step; oProduct is valid
//   oProduct        accumulator plus this cycle's partial product
module seq_multiplier
    import cpu_pkg::*;
(
    input  logic                 iclk,
    input  logic                 irst,
    input  logic                 iStart,
    input  logic [DataWidth-1:0] iMultiplicand,
    input  logic [DataWidth-1:0] iMultiplier,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [DataWidth-1:0] oProduct
);

    logic [DataWidth-1:0] multiplicand;
    logic [DataWidth-1:0] multiplier;
    logic [DataWidth-1:0] acc;
    logic [3:0]           count;
    logic                 busy;

    assign oBusy    = busy;
    assign oDone    = busy && (count == 4'd15);
    assign oProduct = acc + (multiplier[0] ? multiplicand : '0);

    always_ff @(posedge iclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (irst) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            count        <= '0;
            busy         <= 1'b0;
        end else if (busy) begin
            acc          <= oProduct;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count + 4'd1;
            if (count == 4'd15) begin
                busy <= 1'b0;
            end
        end else if (iStart) begin
            acc          <= iMultiplier[0] ? iMultiplicand : '0;
            multiplicand <= iMultiplicand << 1;
            multiplier   <= iMultiplier >> 1;
            count        <= 4'd1;
            busy         <= 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, iterative multiply control, NVZ
// flag register and the EX/MEM pipeline register.
// Ports:
//   iclk, irst                 clock, synchronous active-high reset
//   iOpcode, iData1/2, iSr1/2  decoded instruction and register operands
//   iImm, iALUSrc              immediate and operand-B select
//   iWriteReg..iBusWrite       controls passed to EX/MEM
//   iWriteRegAddr              destination register
//   iWbWrite/iWbAddr/iWbData   MEM/WB forwarding source
//   oALUResult, oStoreData     EX/MEM result/address and store data
//   oWriteReg..oBusWrite       registered controls
//   oNVZ                       {N,V,Z} flags for branch evaluation
//   oStall                     upstream must hold PC and its outputs
module execute_stage
    import cpu_pkg::*;
(
    input  logic                    iclk,
    input  logic                    irst,
    input  logic [OpcodeWidth-1:0]  iOpcode,
    input  logic [DataWidth-1:0]    iData1,
    input  logic [DataWidth-1:0]    iData2,
    input  logic [RegAddrWidth-1:0] iSr1,
    input  logic [RegAddrWidth-1:0] iSr2,
    input  logic [DataWidth-1:0]    iImm,
    input  logic                    iALUSrc,
    input  logic                    iWriteReg,
    input  logic                    iMemtoReg,
    input  logic                    iBustoReg,
    input  logic                    iMemRead,
    input  logic                    iMemWrite,
    input  logic                    iBusWrite,
    input  logic [RegAddrWidth-1:0] iWriteRegAddr,
    input  logic                    iWbWrite,
    input  logic [RegAddrWidth-1:0] iWbAddr,
    input  logic [DataWidth-1:0]    iWbData,
    output logic [DataWidth-1:0]    oALUResult,
    output logic [DataWidth-1:0]    oStoreData,
    output logic                    oWriteReg,
    output logic [RegAddrWidth-1:0] oWriteRegAddr,
    output logic                    oMemtoReg,
    output logic                    oBustoReg,
    output logic                    oMemRead,
    output logic                    oMemWrite,
    output logic                    oBusWrite,
    output logic [2:0]              oNVZ,
    output logic                    oStall
);

    exState_t             state;
    exState_t             stateNext;
    logic                 mulStart;
    logic                 mulBusy;
    logic                 mulDone;
    logic [DataWidth-1:0] mulProduct;
    logic                 exMemFwdValid;
    logic [DataWidth-1:0] srcA;
    logic [DataWidth-1:0] srcB;
    logic [DataWidth-1:0] opB;
    logic [DataWidth-1:0] aluResult;
    logic [2:0]           nvzNext;

    // A load/bus read result is not ready in EX/MEM; MEM/WB covers it later.
    assign exMemFwdValid = oWriteReg && !oMemtoReg && !oBustoReg;

    assign srcA = forwardOperand(exMemFwdValid, oWriteRegAddr, oALUResult,
                                 iWbWrite, iWbAddr, iWbData, iSr1, iData1);
    assign srcB = forwardOperand(exMemFwdValid, oWriteRegAddr, oALUResult,
                                 iWbWrite, iWbAddr, iWbData, iSr2, iData2);
    assign opB  = iALUSrc ? iImm : srcB;

    // Operands are captured only on the accept cycle; later forwarding changes
    // cannot disturb a multiply in flight.
    seq_multiplier uMul (
        .iclk          (iclk),
        .irst          (irst),
        .iStart        (mulStart),
        .iMultiplicand (srcA),
        .iMultiplier   (opB),
        .oBusy         (mulBusy),
        .oDone         (mulDone),
        .oProduct      (mulProduct)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        stateNext = state;
        oStall    = 1'b0;
        mulStart  = 1'b0;
        case (state)
            IDLE: begin
                if (iOpcode == OpMul) begin
                    oStall    = 1'b1;
                    mulStart  = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                oStall = mulBusy && !mulDone;
                if (mulDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        aluResult = '0;
        nvzNext   = oNVZ;
        case (iOpcode)
            OpAdd: begin
                aluResult     = srcA + opB;
                nvzNext[NvzV] = (srcA[15] == opB[15]) && (aluResult[15] != srcA[15]);
            end
            OpSub: begin
                aluResult     = srcA - opB;
                nvzNext[NvzV] = (srcA[15] != opB[15]) && (aluResult[15] != srcA[15]);
            end
            OpAnd:   aluResult = srcA & opB;
            OpOr:    aluResult = srcA | opB;
            OpXor:   aluResult = srcA ^ opB;
            OpSll:   aluResult = srcA << opB[3:0];
            OpSrl:   aluResult = srcA >> opB[3:0];
            OpMul:   aluResult = mulProduct;
            OpImmL:  aluResult = {srcA[15:8], iImm[7:0]};
            OpImmH:  aluResult = {iImm[15:8], srcA[7:0]};
            OpLoad, OpStore, OpDbLoad, OpDbStore: aluResult = srcA + iImm;
            default: aluResult = '0;
        endcase
        // N and Z follow the result for arithmetic, logic, shift and MUL;
        // everything but ADD/SUB also clears V.
        case (iOpcode)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpMul: begin
                nvzNext[NvzN] = aluResult[15];
                nvzNext[NvzZ] = (aluResult == '0);
                if ((iOpcode != OpAdd) && (iOpcode != OpSub)) begin
                    nvzNext[NvzV] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // While stalled the register carries a bubble: controls cleared, data held.
    always_ff @(posedge iclk) begin
        if (irst) begin
            oALUResult    <= '0;
            oStoreData    <= '0;
            oWriteReg     <= 1'b0;
            oWriteRegAddr <= '0;
            oMemtoReg     <= 1'b0;
            oBustoReg     <= 1'b0;
            oMemRead      <= 1'b0;
            oMemWrite     <= 1'b0;
            oBusWrite     <= 1'b0;
            oNVZ          <= 3'b000;
        end else if (oStall) begin
            oWriteReg     <= 1'b0;
            oWriteRegAddr <= '0;
            oMemtoReg     <= 1'b0;
            oBustoReg     <= 1'b0;
            oMemRead      <= 1'b0;
            oMemWrite     <= 1'b0;
            oBusWrite     <= 1'b0;
        end else begin
            oALUResult    <= aluResult;
            oStoreData    <= srcB;
            oWriteReg     <= iWriteReg;
            oWriteRegAddr <= iWriteRegAddr;
            oMemtoReg     <= iMemtoReg;
            oBustoReg     <= iBustoReg;
            oMemRead      <= iMemRead;
            oMemWrite     <= iMemWrite;
            oBusWrite     <= iBusWrite;
            oNVZ          <= nvzNext;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases for arithmetic flags,
// forwarding priority, multiply timing and reset abort, followed by random
// instructions compared against a behavioural model of the stage.
module tb_execute_stage;
    import cpu_pkg::*;

    logic        iclk = 1'b0;
    logic        irst;
    logic [4:0]  iOpcode;
    logic [15:0] iData1, iData2, iImm, iWbData;
    logic [3:0]  iSr1, iSr2, iWriteRegAddr, iWbAddr;
    logic        iALUSrc, iWriteReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite;
    logic        iWbWrite;
    logic [15:0] oALUResult, oStoreData;
    logic        oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite;
    logic [3:0]  oWriteRegAddr;
    logic [2:0]  oNVZ;
    logic        oStall;

    execute_stage dut (
        .iclk(iclk), .irst(irst), .iOpcode(iOpcode),
        .iData1(iData1), .iData2(iData2), .iSr1(iSr1), .iSr2(iSr2),
        .iImm(iImm), .iALUSrc(iALUSrc),
        .iWriteReg(iWriteReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
        .iWriteRegAddr(iWriteRegAddr),
        .iWbWrite(iWbWrite), .iWbAddr(iWbAddr), .iWbData(iWbData),
        .oALUResult(oALUResult), .oStoreData(oStoreData),
        .oWriteReg(oWriteReg), .oWriteRegAddr(oWriteRegAddr),
        .oMemtoReg(oMemtoReg), .oBustoReg(oBustoReg), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .oBusWrite(oBusWrite),
        .oNVZ(oNVZ), .oStall(oStall)
    );

    always #5 iclk = ~iclk;

    // ctl packs {WriteReg, MemtoReg, BustoReg, MemRead, MemWrite, BusWrite}.
    typedef struct {
        logic [4:0]  op;
        logic [15:0] d1, d2, imm, wbData;
        logic [3:0]  sr1, sr2, waddr, wbAddr;
        logic        aluSrc, wbWrite;
        logic [5:0]  ctl;
    } instr_t;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model of the EX/MEM register contents.
    logic [15:0] mRes, mStore;
    logic [2:0]  mNvz;
    logic [5:0]  mCtl;
    logic [3:0]  mAddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compareCount++;
        if (obs !== expv) begin
            mismatchCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mRes = '0; mStore = '0; mNvz = '0; mCtl = '0; mAddr = '0;
    endtask

    task automatic checkOuts(input string tag);
        check({tag, " result"}, oALUResult, mRes);
        check({tag, " store"}, oStoreData, mStore);
        check({tag, " nvz"}, oNVZ, mNvz);
        check({tag, " ctl"}, {oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite}, mCtl);
        check({tag, " waddr"}, oWriteRegAddr, mAddr);
    endtask

    function automatic logic [15:0] fwd(input logic [3:0] sr, input logic [15:0] rf, input instr_t t);
        if (mCtl[5] && !mCtl[4] && !mCtl[3] && (mAddr == sr)) return mRes;
        if (t.wbWrite && (t.wbAddr == sr)) return t.wbData;
        return rf;
    endfunction

    // Reference ALU written from the opcode rules with plain integer arithmetic.
    task automatic refAlu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] imm, input logic [2:0] nvzIn,
                          output logic [15:0] res, output logic [2:0] nvzOut);
        int          sa, sb, s;
        logic [31:0] wide;
        logic        setNZ, v;
        sa = $signed(a);
        sb = $signed(b);
        setNZ = 1'b1;
        v = 1'b0;
        res = '0;
        case (op)
            OpAdd: begin s = sa + sb; res = a + b; v = (s > 32767) || (s < -32768); end
            OpSub: begin s = sa - sb; res = a - b; v = (s > 32767) || (s < -32768); end
            OpAnd: res = a & b;
            OpOr:  res = a | b;
            OpXor: res = a ^ b;
            OpSll: begin wide = {16'h0000, a} << b[3:0]; res = wide[15:0]; end
            OpSrl: res = a >> b[3:0];
            OpMul: begin wide = {16'h0000, a} * {16'h0000, b}; res = wide[15:0]; end
            OpImmL: begin res = {a[15:8], imm[7:0]}; setNZ = 1'b0; end
            OpImmH: begin res = {imm[15:8], a[7:0]}; setNZ = 1'b0; end
            OpLoad, OpStore, OpDbLoad, OpDbStore: begin res = a + imm; setNZ = 1'b0; end
            default: begin res = '0; setNZ = 1'b0; end
        endcase
        nvzOut = setNZ ? {res[15], v, res == 16'h0000} : nvzIn;
    endtask

    task automatic drive(input instr_t t);
        iOpcode = t.op; iData1 = t.d1; iData2 = t.d2; iSr1 = t.sr1; iSr2 = t.sr2;
        iImm = t.imm; iALUSrc = t.aluSrc; iWriteRegAddr = t.waddr;
        {iWriteReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite} = t.ctl;
        iWbWrite = t.wbWrite; iWbAddr = t.wbAddr; iWbData = t.wbData;
    endtask

    function automatic instr_t mkInstr(input logic [4:0] op, input logic [15:0] d1,
                                       input logic [15:0] d2, input logic [15:0] imm);
        instr_t t;
        t.op = op; t.d1 = d1; t.d2 = d2; t.imm = imm;
        t.sr1 = 4'd14; t.sr2 = 4'd15; t.waddr = 4'd13;
        t.aluSrc = 1'b0; t.ctl = 6'b100000;
        t.wbWrite = 1'b0; t.wbAddr = 4'd0; t.wbData = 16'h0000;
        return t;
    endfunction

    // Called just after a rising edge; returns just after the edge that
    // registers the instruction. Upstream holds the inputs while stalled.
    task automatic issue(input instr_t t, input string tag);
        logic [15:0] a, b, res, st;
        logic [2:0]  nvz;
        drive(t);
        #1;
        a = fwd(t.sr1, t.d1, t);
        b = t.aluSrc ? t.imm : fwd(t.sr2, t.d2, t);
        if (t.op == OpMul) begin
            check({tag, " stall accept"}, oStall, 1);
            for (int i = 1; i <= 15; i++) begin
                @(posedge iclk); #1;
                mCtl = '0; mAddr = '0;
                checkOuts($sformatf("%s bubble%0d", tag, i));
                check($sformatf("%s stall%0d", tag, i), oStall, (i < 15) ? 1 : 0);
            end
        end else begin
            check({tag, " stall"}, oStall, 0);
        end
        refAlu(t.op, a, b, t.imm, mNvz, res, nvz);
        st = fwd(t.sr2, t.d2, t);
        @(posedge iclk); #1;
        mRes = res; mNvz = nvz; mStore = st; mCtl = t.ctl; mAddr = t.waddr;
        checkOuts(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instr_t t;
        irst = 1'b1;
        drive(mkInstr(OpAdd, 16'h0, 16'h0, 16'h0));
        modelReset();
        repeat (2) @(posedge iclk);
        #1;
        checkOuts("reset");
        check("reset stall", oStall, 0);
        irst = 1'b0;

        issue(mkInstr(OpAdd, 16'h7FFF, 16'h0001, 16'h0), "add ovf");
        check("add ovf const res", oALUResult, 16'h8000);
        check("add ovf const nvz", oNVZ, 3'b110);

        issue(mkInstr(OpSub, 16'h0005, 16'h0005, 16'h0), "sub zero");
        check("sub zero const nvz", oNVZ, 3'b001);
        t = mkInstr(OpStore, 16'h0200, 16'hBEEF, 16'h0002);
        t.ctl = 6'b000010;
        issue(t, "store");
        check("store keeps nvz", oNVZ, 3'b001);

        t = mkInstr(OpAdd, 16'h0010, 16'h0020, 16'h0);
        t.sr1 = 4'd2; t.sr2 = 4'd3; t.waddr = 4'd1;
        issue(t, "add r1");
        t = mkInstr(OpAdd, 16'h0000, 16'h0000, 16'h0);
        t.sr1 = 4'd1; t.sr2 = 4'd1; t.waddr = 4'd4;
        t.wbWrite = 1'b1; t.wbAddr = 4'd1; t.wbData = 16'h1234;
        issue(t, "add fwd");
        check("fwd const res", oALUResult, 16'h0060);

        issue(mkInstr(OpMul, 16'h0003, 16'h0005, 16'h0), "mul 3x5");
        check("mul 3x5 const res", oALUResult, 16'h000F);
        check("mul 3x5 const nvz", oNVZ, 3'b000);
        issue(mkInstr(OpMul, 16'hFFFF, 16'h0002, 16'h0), "mul neg");
        check("mul neg const res", oALUResult, 16'hFFFE);
        check("mul neg const nvz", oNVZ, 3'b100);

        t = mkInstr(OpLoad, 16'h0100, 16'h5555, 16'h0004);
        t.ctl = 6'b110100;
        issue(t, "load");
        check("load const res", oALUResult, 16'h0104);
        check("load const nvz", oNVZ, 3'b100);

        // Reset during cycle 7 of a multiply.
        drive(mkInstr(OpMul, 16'h1234, 16'h0042, 16'h0));
        #1;
        check("abort stall accept", oStall, 1);
        repeat (7) begin
            @(posedge iclk); #1;
        end
        check("abort stall cycle7", oStall, 1);
        irst = 1'b1;
        @(posedge iclk); #1;
        irst = 1'b0;
        t = mkInstr(OpAdd, 16'h0002, 16'h0003, 16'h0);
        drive(t);
        #1;
        modelReset();
        checkOuts("post reset");
        check("post reset stall", oStall, 0);
        issue(t, "add after reset");
        check("add after reset const", oALUResult, 16'h0005);

        for (int n = 0; n < 150; n++) begin
            t.op      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            t.d1      = 16'($urandom);
            t.d2      = 16'($urandom);
            t.imm     = 16'($urandom);
            t.sr1     = 4'($urandom_range(0, 3));
            t.sr2     = 4'($urandom_range(0, 3));
            t.waddr   = 4'($urandom_range(0, 3));
            t.aluSrc  = 1'($urandom_range(0, 1));
            t.ctl     = 6'($urandom);
            t.wbWrite = 1'($urandom_range(0, 1));
            t.wbAddr  = 4'($urandom_range(0, 3));
            t.wbData  = 16'($urandom);
            issue(t, $sformatf("rand%0d op%0d", n, t.op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
